// File: rtl/noc_pkg.sv
// Shared NoC packet layout, field offsets and injector state encoding.
package noc_pkg;

  localparam int unsigned WIDTH_PACKAGE = 33;
  localparam int unsigned WIDTH_ADDR    = 4;
  localparam int unsigned MAX_NODE      = 12;

  localparam int unsigned DEST_MSB = 32;
  localparam int unsigned DEST_LSB = 29;
  localparam int unsigned SRC_MSB  = 28;
  localparam int unsigned SRC_LSB  = 25;
  localparam int unsigned TYPE_MSB = 24;
  localparam int unsigned TYPE_LSB = 23;
  localparam int unsigned DATA_MSB = 22;

  typedef enum logic [1:0] {
    PktRead  = 2'b00,
    PktWrite = 2'b01,
    PktResp  = 2'b10,
    PktCtrl  = 2'b11
  } pkt_type_e;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } inj_state_e;

  function automatic logic [WIDTH_PACKAGE-1:0] pack_pkt(
    input logic [WIDTH_ADDR-1:0]        dest,
    input logic [WIDTH_ADDR-1:0]        src,
    input logic [TYPE_MSB-TYPE_LSB:0]   ptype,
    input logic [DATA_MSB:0]            data
  );
    logic [WIDTH_PACKAGE-1:0] pkt;
    pkt                    = '0;
    pkt[DEST_MSB:DEST_LSB] = dest;
    pkt[SRC_MSB:SRC_LSB]   = src;
    pkt[TYPE_MSB:TYPE_LSB] = ptype;
    pkt[DATA_MSB:0]        = data;
    return pkt;
  endfunction

endpackage

// File: rtl/noc_tx_fifo.sv
// Synchronous FIFO with occupancy count; head entry is always visible on rdata_o.
module noc_tx_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + PtrW'(1);
    if (pop_i)  rptr_d = rptr_q + PtrW'(1);
    if (push_i && !pop_i) begin
      count_d = count_q + CntW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/noc_packet_injector.sv
// PE-side NoC transmitter: assembles packets, queues them and sends them to the
// router with a two-phase (toggle) bundled-data req/ack handshake.
module noc_packet_injector #(
  parameter int unsigned          WIDTH_PACKAGE = noc_pkg::WIDTH_PACKAGE,
  parameter int unsigned          WIDTH_ADDR    = noc_pkg::WIDTH_ADDR,
  parameter logic [WIDTH_ADDR-1:0] NODE_ADDR    = 4'd5,
  parameter int unsigned          MAX_NODE      = noc_pkg::MAX_NODE,
  parameter int unsigned          DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_ADDR-1:0]        in_dest,
  input  logic [1:0]                   in_type,
  input  logic [noc_pkg::DATA_MSB:0]   in_data,
  output logic                         out_req,
  input  logic                         out_ack,
  output logic [WIDTH_PACKAGE-1:0]     out_data,
  output logic                         err_bad_dest,
  output logic                         err_proto,
  output logic [7:0]                   bad_dest_cnt,
  output logic [$clog2(DEPTH):0]       fifo_count
);

  import noc_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  inj_state_e               state_q, state_d;
  logic                     ack_meta_q, ack_s_q, ack_prev_q;
  logic                     out_req_q, out_req_d;
  logic [WIDTH_PACKAGE-1:0] out_data_q, out_data_d;
  logic                     err_bad_dest_q;
  logic                     err_proto_q, err_proto_d;
  logic [7:0]               bad_cnt_q, bad_cnt_d;
  logic [WIDTH_PACKAGE-1:0] head;
  logic [CntW-1:0]          count;
  logic                     accept, dest_bad, push, pop;

  assign in_ready = rst_n && (count < CntW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign dest_bad = in_dest > WIDTH_ADDR'(MAX_NODE);
  assign push     = accept && !dest_bad;

  noc_tx_fifo #(
    .Width (WIDTH_PACKAGE),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (pack_pkt(in_dest, NODE_ADDR, in_type, in_data)),
    .rdata_o (head),
    .count_o (count)
  );

  assign bad_cnt_d = (accept && dest_bad && bad_cnt_q != 8'hFF) ? bad_cnt_q + 8'd1 : bad_cnt_q;

  always_comb begin
    state_d     = state_q;
    out_req_d   = out_req_q;
    out_data_d  = out_data_q;
    err_proto_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Any ack edge seen while nothing is outstanding is a router fault.
        err_proto_d = (ack_s_q != ack_prev_q);
        if (count != '0) begin
          out_data_d = head;
          out_req_d  = ~out_req_q;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (ack_s_q == out_req_q) begin
          pop     = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ack_meta_q     <= 1'b0;
      ack_s_q        <= 1'b0;
      ack_prev_q     <= 1'b0;
      out_req_q      <= 1'b0;
      out_data_q     <= '0;
      err_bad_dest_q <= 1'b0;
      err_proto_q    <= 1'b0;
      bad_cnt_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      ack_meta_q     <= out_ack;
      ack_s_q        <= ack_meta_q;
      ack_prev_q     <= ack_s_q;
      out_req_q      <= out_req_d;
      out_data_q     <= out_data_d;
      err_bad_dest_q <= accept && dest_bad;
      err_proto_q    <= err_proto_d;
      bad_cnt_q      <= bad_cnt_d;
    end
  end

  assign out_req      = out_req_q;
  assign out_data     = out_data_q;
  assign err_bad_dest = err_bad_dest_q;
  assign err_proto    = err_proto_q;
  assign bad_dest_cnt = bad_cnt_q;
  assign fifo_count   = count;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector with a transaction-level queue model.
`timescale 1ns/1ps
module tb_noc_packet_injector;

  localparam int DEPTH = 4;
  localparam int MAXN  = 12;
  localparam int NODE  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_dest = '0;
  logic [1:0]  in_type = '0;
  logic [22:0] in_data = '0;
  logic        out_req;
  logic        out_ack = 1'b0;
  logic [32:0] out_data;
  logic        err_bad_dest;
  logic        err_proto;
  logic [7:0]  bad_dest_cnt;
  logic [2:0]  fifo_count;

  int n_total = 0;
  int n_pass  = 0;
  int proto_seen = 0;
  int bad_seen   = 0;

  always #5 clk = ~clk;

  noc_packet_injector #(
    .DEPTH     (DEPTH),
    .NODE_ADDR (4'd5),
    .MAX_NODE  (MAXN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dest      (in_dest),
    .in_type      (in_type),
    .in_data      (in_data),
    .out_req      (out_req),
    .out_ack      (out_ack),
    .out_data     (out_data),
    .err_bad_dest (err_bad_dest),
    .err_proto    (err_proto),
    .bad_dest_cnt (bad_dest_cnt),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected progress at %0t", name, $time);
  endtask

  function automatic logic [32:0] pkt(input int dest, input int typ, input int data);
    longint v;
    v = (longint'(dest) << 29) + (longint'(NODE) << 25) + (longint'(typ) << 23) + longint'(data);
    return 33'(v);
  endfunction

  // Model: queue of accepted packets (head is the one on the wire), the
  // router-visible req/data, and error expectations.
  logic [32:0] mq[$];
  bit          m_wait;
  logic        m_req;
  logic [32:0] m_data;
  bit          m_bad, m_proto;
  int          m_cnt;
  logic        m_last_ack;
  int          m_cd;

  always @(posedge clk or negedge rst_n) begin : model
    bit acc, pop_now, launch;
    if (!rst_n) begin
      mq.delete();
      m_wait = 0; m_req = 1'b0; m_data = '0; m_bad = 0; m_proto = 0;
      m_cnt = 0; m_last_ack = 1'b0; m_cd = 0;
    end else begin
      acc   = in_valid && (mq.size() < DEPTH);
      m_bad = acc && (int'(in_dest) > MAXN);
      if (m_bad && m_cnt < 255) m_cnt++;
      m_proto = 0;
      pop_now = 0;
      // An ack edge reaches the decision logic on the third clock edge.
      if (out_ack != m_last_ack) begin
        m_last_ack = out_ack;
        m_cd = 2;
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) begin
          if (m_wait) pop_now = 1;
          else        m_proto = 1;
        end
      end
      launch = !m_wait && (mq.size() > 0);
      if (pop_now) begin
        void'(mq.pop_front());
        m_wait = 0;
      end else if (launch) begin
        m_req  = ~m_req;
        m_data = mq[0];
        m_wait = 1;
      end
      if (acc && !m_bad) mq.push_back(pkt(int'(in_dest), int'(in_type), int'(in_data)));
    end
  end

  always @(negedge clk) begin : compare
    check("in_ready",     33'(in_ready),     33'(rst_n && (mq.size() < DEPTH)));
    check("fifo_count",   33'(fifo_count),   33'(mq.size()));
    check("out_req",      33'(out_req),      33'(m_req));
    check("out_data",     out_data,          m_data);
    check("err_bad_dest", 33'(err_bad_dest), 33'(m_bad));
    check("err_proto",    33'(err_proto),    33'(m_proto));
    check("bad_dest_cnt", 33'(bad_dest_cnt), 33'(m_cnt));
    if (err_proto)    proto_seen++;
    if (err_bad_dest) bad_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) fail("accept_timeout");
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] d, input logic [1:0] t, input logic [22:0] x);
    in_valid = 1'b1; in_dest = d; in_type = t; in_data = x;
    wait_accept();
  endtask

  task automatic ack_router();
    bit pend;
    pend = 0;
    for (int i = 0; i < 40 && !pend; i++) begin
      @(negedge clk);
      pend = (out_req != out_ack);
    end
    if (!pend) fail("req_timeout");
    tick();
    out_ack = ~out_ack;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset with a pending request: no handshake while rst_n is low.
    in_valid = 1'b1; in_dest = 4'd9;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 33'(in_ready), 33'(0));
    check("rst_out_req",  33'(out_req),  33'(0));
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 33'(in_ready),   33'(1));
    check("post_rst_count", 33'(fifo_count), 33'(0));

    // Single packet: req toggles one edge after accept.
    tick();
    send(4'd9, 2'b01, 23'h1234);
    @(negedge clk);
    check("single_count", 33'(fifo_count), 33'(1));
    check("single_req0",  33'(out_req),    33'(0));
    @(negedge clk);
    check("single_req1",  33'(out_req),    33'(1));
    check("single_data",  out_data,        33'h1_2A80_1234);
    tick();
    out_ack = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("single_drained", 33'(fifo_count), 33'(0));

    // Five back-to-back with ack held; fifth (loopback) stalls until a pop.
    tick();
    for (int i = 0; i < 4; i++) send(4'(i + 1), 2'(i), 23'(32'h100 + i));
    in_valid = 1'b1; in_dest = 4'd5; in_type = 2'b11; in_data = 23'h7F_FFFF;
    repeat (4) tick();
    @(negedge clk);
    check("burst_full",  33'(fifo_count), 33'(4));
    check("burst_ready", 33'(in_ready),   33'(0));
    check("burst_req",   33'(out_req),    33'(0));
    tick();
    out_ack = ~out_ack;
    wait_accept();
    repeat (4) ack_router();
    repeat (6) tick();
    @(negedge clk);
    check("burst_drained", 33'(fifo_count), 33'(0));
    check("burst_req_end", 33'(out_req),    33'(0));

    // Illegal destinations are consumed but never queued.
    tick();
    send(4'd13, 2'b00, 23'h1);
    send(4'd15, 2'b10, 23'h2);
    tick();
    @(negedge clk);
    check("bad_cnt2",   33'(bad_dest_cnt), 33'(2));
    check("bad_count",  33'(fifo_count),   33'(0));
    check("bad_req",    33'(out_req),      33'(0));
    tick();
    in_valid = 1'b1; in_dest = 4'd14;
    repeat (256) tick();
    in_valid = 1'b0;
    tick();
    @(negedge clk);
    check("bad_cnt_sat",  33'(bad_dest_cnt), 33'(255));
    check("bad_pulses",   33'(bad_seen),     33'(258));

    // Reset while waiting on an ack with three packets held.
    tick();
    send(4'd0,  2'b00, 23'h11);
    send(4'd7,  2'b01, 23'h22);
    send(4'd12, 2'b10, 23'h33);
    @(negedge clk);
    check("wait_count", 33'(fifo_count), 33'(3));
    check("wait_req",   33'(out_req),    33'(1));
    #2;
    rst_n = 1'b0;
    out_ack = 1'b0;
    #1;
    check("async_req",   33'(out_req),    33'(0));
    check("async_data",  out_data,        33'(0));
    check("async_count", 33'(fifo_count), 33'(0));
    check("async_ready", 33'(in_ready),   33'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("no_stale_req",   33'(out_req),    33'(0));
    check("no_stale_count", 33'(fifo_count), 33'(0));

    // Unexpected ack toggle in IDLE.
    tick();
    out_ack = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("proto_pulses", 33'(proto_seen), 33'(1));
    check("proto_req",    33'(out_req),    33'(0));
    check("proto_data",   out_data,        33'(0));
    check("proto_count",  33'(fifo_count), 33'(0));

    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
- Clocked network-interface transmitter on the PE/memory side of a NoC node.
- Accepts PE transfer requests over a valid/ready interface and assembles 33-bit packets: destination in [32:29], source in [28:25], type in [24:23], payload in [22:0].
- Buffers packets in a small FIFO and drives them into the router's pe_mem_in port using the two-phase bundled-data protocol (req toggle / ack toggle) the router channels use.

Parameters:
- WIDTH_PACKAGE, 33, packet width.
- WIDTH_ADDR, 4, node address width.
- NODE_ADDR, 4'd5, this node's address, inserted in the source field.
- MAX_NODE, 12, highest legal destination address.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  PE request valid.
- in_ready  out  1  injector can accept.
- in_dest  in  4  destination node address.
- in_type  in  2  packet type.
- in_data  in  23  payload.
- out_req  out  1  two-phase request to the router; a toggle means new data.
- out_ack  in  1  two-phase acknowledge from the router; asynchronous to clk.
- out_data  out  33  bundled packet data.
- err_bad_dest  out  1  one-cycle pulse when a request with in_dest > MAX_NODE is dropped.
- err_proto  out  1  one-cycle pulse on an unexpected ack toggle.
- bad_dest_cnt  out  8  saturating count of dropped requests.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync deassert is the system's job):
  - out_req=0, out_data=0, FIFO empty, fifo_count=0.
  - err_bad_dest=0, err_proto=0, bad_dest_cnt=0.
  - Both ack synchronizer flops cleared; FSM in IDLE.
  - in_ready=0 while rst_n low.
- Handshake in:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - in_ready = (fifo_count < DEPTH). It does not depend on a same-cycle pop.
- Packet assembly on accept: {in_dest, NODE_ADDR, in_type, in_data}.
  - If in_dest > MAX_NODE: the handshake still completes, nothing is enqueued, err_bad_dest pulses on the next cycle, and bad_dest_cnt increments, saturating at 255.
  - Loopback (in_dest == NODE_ADDR) is legal and is enqueued.
- out_ack passes through a two-flop synchronizer (ack_s); all decisions use ack_s only.
- FSM:
  - IDLE: when the FIFO is non-empty, on the next edge load out_data with the head entry, toggle out_req, and go to WAIT. out_data is registered and changes only on this edge, so data is stable before the req edge, as bundled-data requires.
  - WAIT: hold out_data and out_req. When ack_s == out_req, on that edge pop the head and go to IDLE. The next packet launches no earlier than the following edge.
  - IDLE with ack_s != out_req: err_proto pulses one cycle and the toggle is otherwise ignored. No state change and no pop.
- Latency and throughput:
  - Accept at edge N into an empty FIFO in IDLE → out_req toggles at edge N+1.
  - Ack toggle → pop 2–3 edges later.
  - Minimum spacing between req toggles is 4 cycles.
- Simultaneous events:
  - Push and pop on the same edge: count is unchanged, and the pushed entry lands behind the head.
  - Push into a FIFO with DEPTH-1 entries while popping: allowed, since in_ready was 1.
  - A bad-dest accept and a pop on the same edge: count decrements by 1 only.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from fifo_count.
- Reset mid-WAIT abandons the in-flight packet; out_req returns to 0. The router side must be reset simultaneously (system requirement).

Decomposition:
- Package noc_pkg:
  - WIDTH_PACKAGE, WIDTH_ADDR, MAX_NODE.
  - Field offset localparams DEST_MSB=32, DEST_LSB=29, SRC_MSB=28, SRC_LSB=25, TYPE_MSB=24, TYPE_LSB=23, DATA_MSB=22.
  - pkt_type_e enum (2 bits).
  - Injector FSM state enum {IDLE, WAIT}.
- Sub-module noc_tx_fifo: a synchronous FIFO with async active-low reset, push/pop/count, and head data always visible. The FSM and synchronizer stay in the top module.

Test Plan:
- Reset with in_valid=1 → in_ready=0 and out_req=0 while rst_n low; after release in_ready=1, fifo_count=0.
- Single request dest=9, type=2'b01, data=23'h1234 with NODE_ADDR=5 → out_data=33'b1001_0101_01_<0x1234> and out_req toggles 0→1 one edge after accept. Ack toggled 0→1 → pop within 3 edges, fifo_count=0, IDLE.
- Push 5 requests back-to-back with ack held (DEPTH=4) → in_ready drops after 4 accepts, fifo_count=4, out_req toggled once. Subsequent acks drain them in order, one req toggle per ack, and in_ready returns to 1 after the first pop.
- Request with dest=13, then dest=15 → both handshakes complete, no enqueue, no out_req toggle, err_bad_dest pulses twice, bad_dest_cnt=2. 256 further bad requests → bad_dest_cnt saturates at 255.
- Toggle out_ack while IDLE with an empty FIFO → err_proto pulses one cycle; out_req, out_data and fifo_count are unchanged.
- Assert rst_n low during WAIT with 3 entries queued → outputs go to reset values immediately, without waiting for a clock edge; after release no stale packet is sent and fifo_count=0.
